apb_initiator: RTL
==================

// Module: apb_initiator
// PURPOSE
//  APB4 requester: turns a valid/ready command stream (CPU bridge, debug port, DMA) into APB
//  setup/access transfers toward the CSR slaves, and returns read data and error status on a
//  valid/ready response stream. One outstanding transfer; wait states via pready; optional timeout.
// PARAMETERS
//  ADDR_W   16          APB/command address width
//  DATA_W   32          data width (multiple of 8)
//  STRB_W   DATA_W/8    byte-strobe width
//  TIMEOUT  255         max ACCESS cycles waiting for pready; 0 = wait forever
// PORTS
//  clk        in   1       system clock
//  rst        in   1       reset; one clock, synchronous, active-high
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when valid&ready
//  cmd_write  in   1       1 = write, 0 = read
//  cmd_addr   in   ADDR_W  byte address
//  cmd_wdata  in   DATA_W  write data
//  cmd_wstrb  in   STRB_W  write byte strobes (ignored for reads)
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       response consumed when valid&ready
//  rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
//  rsp_slverr out  1       slave returned pslverr
//  rsp_tmo    out  1       transfer aborted by timeout
//  psel/penable/pwrite out 1; paddr out ADDR_W; pwdata out DATA_W; pstrb out STRB_W
//  prdata in DATA_W; pready in 1; pslverr in 1   (standard APB4 semantics)
// BEHAVIOUR
//  - Reset (rst=1 at edge): state IDLE; all outputs 0 except cmd_ready=1 after the edge;
//    timeout counter 0. Reset mid-transfer drops psel/penable at that edge; response discarded.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All APB and rsp outputs registered.
//  - cmd_ready = (state==IDLE) | (state==RESP & rsp_ready). Accept registers cmd_*, next SETUP.
//  - SETUP: psel=1, penable=0, paddr/pwrite/pwdata/pstrb from captured cmd; pstrb=0 on reads.
//    Always exactly one cycle, then ACCESS.
//  - ACCESS: psel=1, penable=1, address/control/data held stable. On pready=1: sample prdata
//    (reads only) and pslverr; next cycle psel=penable=0, state RESP, rsp_valid=1.
//  - Timeout: counter clears entering ACCESS, +1 per ACCESS cycle with pready=0; at count==TIMEOUT
//    abort: psel/penable drop, RESP with rsp_tmo=1, rsp_slverr=0, rsp_rdata=0. Width
//    $clog2(TIMEOUT+1); TIMEOUT=0 disables counter (never aborts).
//  - pready and timeout in same cycle: pready wins (normal completion, rsp_tmo=0).
//  - RESP: rsp_* held stable until rsp_ready. If rsp_ready & cmd_valid same cycle the new command
//    is accepted and next state is SETUP (no IDLE bubble); else with rsp_ready go IDLE.
//  - Latency, zero wait states: accept at edge N; psel at N+1; penable at N+2; rsp_valid at N+3.
//    Each pready=0 cycle adds one. Back-to-back throughput: one transfer per 3 cycles.
//  - paddr/pwrite/pwdata hold last values when idle; pstrb returns to 0 when psel=0.
//  - pready/pslverr/prdata ignored whenever penable=0.
// STRUCTURE
//  - Shared package apb_pkg: FSM state encoding (IDLE, SETUP, ACCESS, RESP), APB4 response
//    code constants (OKAY, SLVERR, TMO); reused by slave-side blocks and benches.
//  - Flat module; no sub-module needed (timeout counter is a few lines, kept inline).
// TESTING
//  - Zero-wait write addr 0x0008 wdata 0x31 wstrb 0x1, pready=1 -> psel N+1, penable N+2,
//    rsp_valid N+3, rsp_slverr=0, rsp_tmo=0, pstrb=0x1 throughout SETUP/ACCESS.
//  - Read 0x0FFC, slave holds pready=0 for 3 cycles then prdata=0xCAFE0666 -> rsp_rdata=0xCAFE0666
//    at N+6; pstrb=0 and paddr stable across all ACCESS cycles.
//  - TIMEOUT=4, slave never asserts pready -> psel drops after 4 ACCESS cycles, rsp_tmo=1, rdata=0.
//  - Slave returns pslverr=1 with pready on write 0x0010 -> rsp_slverr=1; rsp held while
//    rsp_ready=0 for 5 cycles, cmd_ready=0 during hold.
//  - Back-to-back: cmd_valid held with 2 commands, rsp_ready=1 -> second SETUP on cycle after
//    first RESP, no IDLE cycle; rst=1 asserted during second ACCESS -> psel=0, rsp_valid=0 next cycle.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared APB requester state encoding and response codes.
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;
  typedef enum logic [1:0] {RSP_OKAY, RSP_SLVERR, RSP_TMO} apb_rsp_e;
  function automatic apb_rsp_e rsp_code(input logic slverr, input logic tmo);
    return tmo ? RSP_TMO : slverr ? RSP_SLVERR : RSP_OKAY;
  endfunction
endpackage

// File: rtl/apb_initiator_if.sv
// apb_initiator_if: command/response streams plus APB4 bus of the requester.
interface apb_initiator_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_slverr;
  logic              rsp_tmo;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_tmo, psel, penable, pwrite, paddr, pwdata, pstrb
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_tmo, psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/apb_initiator.sv
// apb_initiator: APB4 requester turning a valid/ready command stream into single APB transfers.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  apb_initiator_if.master bus
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  apb_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_tmo;
  assign bus.cmd_ready = (r_state == IDLE) || (r_state == RESP && bus.rsp_ready);
  assign w_accept      = bus.cmd_valid && bus.cmd_ready;
  // abort on the TIMEOUT-th ACCESS cycle without pready; pready is checked first so it wins
  assign w_tmo         = TIMEOUT != 0 && int'(r_cnt) + 1 == TIMEOUT;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      bus.psel       <= 1'b0;
      bus.penable    <= 1'b0;
      bus.pwrite     <= 1'b0;
      bus.paddr      <= '0;
      bus.pwdata     <= '0;
      bus.pstrb      <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_slverr <= 1'b0;
      bus.rsp_tmo    <= 1'b0;
    end else if (w_accept) begin
      r_state       <= SETUP;
      bus.psel      <= 1'b1;
      bus.pwrite    <= bus.cmd_write;
      bus.paddr     <= bus.cmd_addr;
      bus.pwdata    <= bus.cmd_wdata;
      bus.pstrb     <= bus.cmd_write ? bus.cmd_wstrb : '0;
      bus.rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        SETUP: begin
          r_state     <= ACCESS;
          bus.penable <= 1'b1;
          r_cnt       <= '0;
        end
        ACCESS: begin
          if (bus.pready || w_tmo) begin
            r_state        <= RESP;
            bus.psel       <= 1'b0;
            bus.penable    <= 1'b0;
            bus.pstrb      <= '0;
            bus.rsp_valid  <= 1'b1;
            bus.rsp_rdata  <= bus.pready && !bus.pwrite ? bus.prdata : '0;
            bus.rsp_slverr <= bus.pready && bus.pslverr;
            bus.rsp_tmo    <= !bus.pready;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state       <= IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
